// File: rtl/load_pkg.sv
// Shared definitions for the load alignment path: load type encodings,
// FSM state encoding and the default WAIT timeout.
package load_pkg;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LHU = 3'd2;
  localparam logic [2:0] LD_LB  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;

  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/load_extract.sv
// Combinational byte/halfword select plus sign/zero extension of a
// little-endian memory word; shared with the single-cycle CPU datapath.
module load_extract
  import load_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  ld_type,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword select uses only offset[1], so odd halfword addresses fold down.
  assign byte_sel = word[{offset, 3'b000} +: 8];
  assign half_sel = word[{offset[1], 4'b0000} +: 16];

  always_comb begin
    result = 32'd0;
    case (ld_type)
      LD_LW:   result = word;
      LD_LH:   result = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  result = {16'd0, half_sel};
      LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  result = {24'd0, byte_sel};
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_align.sv
// Load request sequencer: word-aligned memory read, timeout abort, result
// extraction and valid/ready return. Define LOAD_MISALIGN_TRAP_EN to abort
// misaligned LW/LH/LHU instead of masking the low address bits.
//
// state | meaning
// IDLE  | ready for a request
// REQ   | one-cycle dm_req strobe, timeout counter cleared
// WAIT  | waiting for dm_rvalid or timeout
// RESP  | holding result until writeback accepts it
module load_align
  import load_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_type,
  output logic        dm_req,
  output logic [31:0] dm_addr,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic        rd_err,
  output logic        busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       off_q;
  logic [2:0]       type_q;
  logic             legal;
  logic             misalign;
  logic             abort_now;
  logic             timed_out;
  logic [31:0]      ext_data;

  assign ld_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign legal     = (ld_type <= LD_LBU);
  assign timed_out = (cnt == CNT_LAST);

`ifdef LOAD_MISALIGN_TRAP_EN
  assign misalign = ((ld_type == LD_LW) && (ld_addr[1:0] != 2'b00)) ||
                    (((ld_type == LD_LH) || (ld_type == LD_LHU)) && ld_addr[0]);
`else
  assign misalign = 1'b0;
`endif

  assign abort_now = !legal || misalign;

  load_extract u_extract (
    .word    (dm_rdata),
    .offset  (off_q),
    .ld_type (type_q),
    .result  (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ld_valid) state_nxt = abort_now ? RESP : REQ;
      REQ:  state_nxt = WAIT;
      WAIT: if (dm_rvalid || timed_out) state_nxt = RESP;
      RESP: if (rd_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_req   <= 1'b0;
      dm_addr  <= 32'd0;
      rd_valid <= 1'b0;
      rd_data  <= 32'd0;
      rd_err   <= 1'b0;
      cnt      <= '0;
      off_q    <= 2'd0;
      type_q   <= 3'd0;
    end else begin
      dm_req <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_valid) begin
            off_q   <= ld_addr[1:0];
            type_q  <= ld_type;
            dm_addr <= {ld_addr[31:2], 2'b00};
            if (abort_now) begin
              rd_valid <= 1'b1;
              rd_err   <= 1'b1;
              rd_data  <= 32'd0;
            end else begin
              dm_req <= 1'b1;
            end
          end
        end
        REQ: cnt <= '0;
        WAIT: begin
          // Data arriving on the timeout cycle still completes the load.
          if (dm_rvalid) begin
            rd_valid <= 1'b1;
            rd_err   <= 1'b0;
            rd_data  <= ext_data;
          end else if (timed_out) begin
            rd_valid <= 1'b1;
            rd_err   <= 1'b1;
            rd_data  <= 32'd0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: if (rd_ready) rd_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/load_align.md
Name: load_align

Overview:
- Read-side counterpart to the store-byte merge path in the pipelined CPU's MEM stage.
- Accepts a load request (LW/LH/LHU/LB/LBU) and issues a word-aligned read to data memory. Waits for the memory response, then extracts and sign/zero-extends the addressed byte or halfword.
- Returns the result to writeback through a valid/ready handshake.
- Drives a busy signal so the hazard unit can stall the pipeline while a load is outstanding.

Parameters:
- TIMEOUT, 16: max cycles in WAIT before aborting with error; valid range 2..255.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ld_valid  input  1  load request valid.
- ld_ready  output  1  unit can accept a request; high only in IDLE.
- ld_addr  input  32  byte address.
- ld_type  input  3  0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU; 5-7 are illegal.
- dm_req  output  1  one-cycle memory read strobe.
- dm_addr  output  32  word-aligned read address: {addr[31:2],2'b00}.
- dm_rvalid  input  1  memory read data valid.
- dm_rdata  input  32  memory read word, little-endian (byte 0 = bits 7:0).
- rd_valid  output  1  result valid; held until accepted.
- rd_ready  input  1  writeback accepts the result.
- rd_data  output  32  extended load result.
- rd_err  output  1  qualifies rd_valid: request was aborted (timeout, illegal type, or misalignment).
- busy  output  1  high in every state except IDLE.

Behaviour:
- Decided: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: state=IDLE. ld_ready=1; dm_req=0; dm_addr=0; rd_valid=0; rd_data=0; rd_err=0; busy=0; timeout counter=0; latched address/type=0.
- All outputs are registered except ld_ready and busy, which decode directly from state.

FSM states and transitions:
- IDLE:
  - On ld_valid&&ld_ready: latch addr[1:0] and ld_type; drive dm_addr.
  - Legal request → go to REQ.
  - Illegal ld_type → go to RESP with rd_err=1, rd_data=0.
- REQ: dm_req=1 for exactly this one cycle; clear counter; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - dm_rvalid → capture extracted result into rd_data, rd_err=0, go to RESP.
  - Counter reaches TIMEOUT-1 without dm_rvalid → rd_err=1, rd_data=0, go to RESP.
  - If dm_rvalid and timeout occur in the same cycle, dm_rvalid wins.
- RESP:
  - rd_valid=1; rd_data and rd_err are stable while rd_valid is high.
  - rd_valid&&rd_ready → rd_valid=0, go to IDLE.
- dm_rvalid outside WAIT is ignored.
- Latency with immediate memory response:
  - ld accept in cycle 0, dm_req in cycle 1.
  - dm_rvalid sampled in cycle 2 at the earliest.
  - rd_valid high from cycle 3; next request accepted in cycle 4 at the earliest.

Extraction (b = latched addr[1:0]):
- LW: dm_rdata unchanged.
- LB/LBU: byte = dm_rdata[8b+7:8b]; LB sign-extends bit 7, LBU zero-extends.
- LH/LHU: half = dm_rdata[16*b[1]+15:16*b[1]]; LH sign-extends bit 15, LHU zero-extends.

Reset mid-operation: any state returns to IDLE immediately. A dm_rvalid arriving after reset is dropped.

Optional Feature:
- Macro: LOAD_MISALIGN_TRAP_EN.
- Defined:
  - In IDLE, a misaligned request is one of: LW with addr[1:0]!=0, or LH/LHU with addr[0]=1.
  - A misaligned request skips REQ/WAIT (no dm_req) and goes directly to RESP with rd_err=1, rd_data=0.
- Undefined:
  - Low address bits are masked: LW ignores addr[1:0]; LH/LHU ignore addr[0].
  - No error is raised for misalignment.

Decomposition:
- Shared package load_pkg:
  - ld_type encodings LD_LW..LD_LBU.
  - State enum IDLE/REQ/WAIT/RESP.
  - Default TIMEOUT.
- One natural sub-module: load_extract, purely combinational.
  - Inputs: word, offset, type.
  - Output: 32-bit extended value.
  - Instantiated once; reusable by the single-cycle CPU.

Test Plan:
- LB addr=0x103, dm_rdata=0x80FF_1234, rvalid one cycle after dm_req → dm_addr=0x100, rd_data=0xFFFF_FF80, rd_err=0, rd_valid in cycle 3.
- LBU addr=0x101 and LHU addr=0x102, dm_rdata=0x80FF_1234 → rd_data=0x0000_0012 and 0x0000_80FF; LH addr=0x102 → 0xFFFF_80FF.
- LW addr=0x200, dm_rvalid never asserted, TIMEOUT=16 → rd_valid with rd_err=1, rd_data=0 after 16 WAIT cycles; busy high throughout.
- rd_ready held low for 5 cycles in RESP → rd_valid/rd_data stable, ld_ready=0; a new ld_valid is not accepted until after the handshake.
- rst_n asserted during WAIT, then dm_rvalid pulses → all outputs at reset values, no rd_valid; the next request completes normally.
- LH addr=0x101: with LOAD_MISALIGN_TRAP_EN → no dm_req, rd_err=1 in cycle 1. Without it → dm_req issued and the halfword at offset 0 is returned.
